// File: rtl/cpu_regfile_sequencer_pkg.sv
// Shared types and constants for the register-file sequencer slice:
// read FSM states, register-file geometry and arbiter requester ids.
package cpu_regseq_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  localparam logic ARB_ALU = 1'b0;
  localparam logic ARB_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } read_state_e;

  // One-hot mask for a register index; x0 never maps to a scoreboard bit.
  function automatic logic [REG_COUNT-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [REG_COUNT-1:0] mask;
    mask = '0;
    if (idx != '0) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/cpu_regfile_sequencer_if.sv
// Decode/issue, writeback and register-file bus of the sequencer.
// slave = the sequencer, master = the surrounding pipeline and register file.
interface cpu_regfile_sequencer_if #(
  parameter int TAG_WIDTH = 8
);
  logic                 i_read_req;
  logic [4:0]           i_read_rs1_idx;
  logic [4:0]           i_read_rs2_idx;
  logic                 o_read_valid;
  logic [TAG_WIDTH-1:0] o_read_tag;
  logic [4:0]           o_read_rs1_idx;
  logic [4:0]           o_read_rs2_idx;
  logic                 i_issue_valid;
  logic [4:0]           i_issue_rd;
  logic                 o_issue_ready;
  logic                 i_wb_alu_valid;
  logic [4:0]           i_wb_alu_rd;
  logic [31:0]          i_wb_alu_data;
  logic                 o_wb_alu_ready;
  logic                 i_wb_lsu_valid;
  logic [4:0]           i_wb_lsu_rd;
  logic [31:0]          i_wb_lsu_data;
  logic                 o_wb_lsu_ready;
  logic [TAG_WIDTH-1:0] o_write_tag;
  logic [4:0]           o_write_rd_idx;
  logic [31:0]          o_rd;
  logic [31:0]          o_pending;

  modport slave (
    input  i_read_req, i_read_rs1_idx, i_read_rs2_idx,
    input  i_issue_valid, i_issue_rd,
    input  i_wb_alu_valid, i_wb_alu_rd, i_wb_alu_data,
    input  i_wb_lsu_valid, i_wb_lsu_rd, i_wb_lsu_data,
    output o_read_valid, o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
    output o_issue_ready, o_wb_alu_ready, o_wb_lsu_ready,
    output o_write_tag, o_write_rd_idx, o_rd, o_pending
  );

  modport master (
    output i_read_req, i_read_rs1_idx, i_read_rs2_idx,
    output i_issue_valid, i_issue_rd,
    output i_wb_alu_valid, i_wb_alu_rd, i_wb_alu_data,
    output i_wb_lsu_valid, i_wb_lsu_rd, i_wb_lsu_data,
    input  o_read_valid, o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
    input  o_issue_ready, o_wb_alu_ready, o_wb_lsu_ready,
    input  o_write_tag, o_write_rd_idx, o_rd, o_pending
  );
endinterface

// File: rtl/cpu_regfile_sequencer_arbiter.sv
// Two-way round-robin arbiter for the single register-file write port.
// A granted x0 write is accepted and rotates priority but does not commit.
module cpu_wb_rr_arbiter
  import cpu_regseq_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [31:0]          alu_data,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [31:0]          lsu_data,
  output logic                 alu_ready,
  output logic                 lsu_ready,
  output logic                 commit,
  output logic [REG_IDX_W-1:0] commit_rd,
  output logic [31:0]          commit_data
);

  logic prio_reg;
  logic prio_next;
  logic grant_lsu;
  logic any_grant;

  always_comb begin
    any_grant   = alu_valid | lsu_valid;
    grant_lsu   = lsu_valid & (~alu_valid | (prio_reg == ARB_LSU));
    alu_ready   = alu_valid & ~grant_lsu;
    lsu_ready   = grant_lsu;
    commit_rd   = grant_lsu ? lsu_rd   : alu_rd;
    commit_data = grant_lsu ? lsu_data : alu_data;
    commit      = any_grant & (commit_rd != '0);
    prio_next   = prio_reg;
    if (any_grant) prio_next = grant_lsu ? ARB_ALU : ARB_LSU;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) prio_reg <= (RR_INIT != 0) ? ARB_LSU : ARB_ALU;
    else         prio_reg <= prio_next;
  end

endmodule

// File: rtl/cpu_regfile_sequencer.sv
// Tag-handshake sequencer in front of the register file: read FSM, pending-write
// scoreboard and writeback arbitration. CPU_REGSEQ_PERF_EN adds stall/conflict counters.
module cpu_regfile_sequencer
  import cpu_regseq_pkg::*;
#(
  parameter int TAG_WIDTH = 8,
  parameter int RR_INIT   = 0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  cpu_regfile_sequencer_if.slave  bus
`ifdef CPU_REGSEQ_PERF_EN
  ,
  output logic [31:0]             o_stall_cycles,
  output logic [31:0]             o_wb_conflicts
`endif
);

  read_state_e            state_reg, state_next;
  logic [TAG_WIDTH-1:0]   read_tag_reg;
  logic [TAG_WIDTH-1:0]   write_tag_reg;
  logic [REG_IDX_W-1:0]   rs1_reg, rs2_reg;
  logic [REG_IDX_W-1:0]   write_rd_reg;
  logic [31:0]            write_data_reg;
  logic [REG_COUNT-1:0]   pending_reg, pending_next;

  logic                   hazard, issue_ready;
  logic                   latch_idx, read_tag_inc;
  logic                   commit;
  logic [REG_IDX_W-1:0]   commit_rd;
  logic [31:0]            commit_data;

  cpu_wb_rr_arbiter #(.RR_INIT(RR_INIT)) u_arb (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .alu_valid  (bus.i_wb_alu_valid),
    .alu_rd     (bus.i_wb_alu_rd),
    .alu_data   (bus.i_wb_alu_data),
    .lsu_valid  (bus.i_wb_lsu_valid),
    .lsu_rd     (bus.i_wb_lsu_rd),
    .lsu_data   (bus.i_wb_lsu_data),
    .alu_ready  (bus.o_wb_alu_ready),
    .lsu_ready  (bus.o_wb_lsu_ready),
    .commit     (commit),
    .commit_rd  (commit_rd),
    .commit_data(commit_data)
  );

  // Hazard looks only at the registered scoreboard, so a write granted this
  // cycle releases the read one edge after its write tag moves.
  always_comb begin
    hazard       = ((rs1_reg != '0) && pending_reg[rs1_reg]) ||
                   ((rs2_reg != '0) && pending_reg[rs2_reg]);
    issue_ready  = (bus.i_issue_rd == '0) || !pending_reg[bus.i_issue_rd];
    pending_next = pending_reg & ~(commit ? idx_onehot(commit_rd) : '0);
    if (bus.i_issue_valid && issue_ready)
      pending_next = pending_next | idx_onehot(bus.i_issue_rd);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.i_read_req) state_next = CHECK;
      CHECK:   if (!hazard)        state_next = ISSUE;
      ISSUE:                       state_next = DONE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_idx        = (state_reg == IDLE) && bus.i_read_req;
    read_tag_inc     = (state_reg == CHECK) && !hazard;
    bus.o_read_valid = (state_reg == DONE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      read_tag_reg   <= '0;
      write_tag_reg  <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      write_rd_reg   <= '0;
      write_data_reg <= '0;
      pending_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (latch_idx) begin
        rs1_reg <= bus.i_read_rs1_idx;
        rs2_reg <= bus.i_read_rs2_idx;
      end
      if (read_tag_inc) read_tag_reg <= read_tag_reg + 1'b1;
      if (commit) begin
        write_tag_reg  <= write_tag_reg + 1'b1;
        write_rd_reg   <= commit_rd;
        write_data_reg <= commit_data;
      end
    end
  end

`ifdef CPU_REGSEQ_PERF_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
      o_wb_conflicts <= '0;
    end else begin
      if ((state_reg == CHECK) && hazard)            o_stall_cycles <= o_stall_cycles + 1'b1;
      if (bus.i_wb_alu_valid && bus.i_wb_lsu_valid)  o_wb_conflicts <= o_wb_conflicts + 1'b1;
    end
  end
`endif

  assign bus.o_read_tag     = read_tag_reg;
  assign bus.o_read_rs1_idx = rs1_reg;
  assign bus.o_read_rs2_idx = rs2_reg;
  assign bus.o_issue_ready  = issue_ready;
  assign bus.o_write_tag    = write_tag_reg;
  assign bus.o_write_rd_idx = write_rd_reg;
  assign bus.o_rd           = write_data_reg;
  assign bus.o_pending      = pending_reg;

endmodule

// File: tb/tb_cpu_regfile_sequencer.sv
// Directed bench for cpu_regfile_sequencer with a small tag-driven register file model.
module tb_cpu_regfile_sequencer;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 i_clock = ~i_clock;

  cpu_regfile_sequencer_if #(.TAG_WIDTH(8)) bus ();

`ifdef CPU_REGSEQ_PERF_EN
  logic [31:0] o_stall_cycles, o_wb_conflicts;
`endif

  cpu_regfile_sequencer #(.TAG_WIDTH(8), .RR_INIT(0)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus    (bus)
`ifdef CPU_REGSEQ_PERF_EN
    ,
    .o_stall_cycles(o_stall_cycles),
    .o_wb_conflicts(o_wb_conflicts)
`endif
  );

  // Register file model: commits on a write-tag change, samples on a read-tag change.
  logic [31:0] rf_mem [32];
  logic [7:0]  rf_wtag_prev, rf_rtag_prev;
  logic [31:0] rf_rs1, rf_rs2;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < 32; r++) rf_mem[r] <= '0;
      rf_wtag_prev <= '0;
      rf_rtag_prev <= '0;
      rf_rs1       <= '0;
      rf_rs2       <= '0;
    end else begin
      if (bus.o_write_tag != rf_wtag_prev) begin
        rf_wtag_prev <= bus.o_write_tag;
        if (bus.o_write_rd_idx != 5'd0) rf_mem[bus.o_write_rd_idx] <= bus.o_rd;
      end
      if (bus.o_read_tag != rf_rtag_prev) begin
        rf_rtag_prev <= bus.o_read_tag;
        rf_rs1       <= rf_mem[bus.o_read_rs1_idx];
        rf_rs2       <= rf_mem[bus.o_read_rs2_idx];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Ticks until o_read_valid is seen; returns the tick count or -1 on timeout.
  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (bus.o_read_valid) begin
        n = t;
        break;
      end
    end
  endtask

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        exp_alu_rdy;
    logic        exp_lsu_rdy;
    logic [7:0]  exp_tag;
    logic [4:0]  exp_idx;
    logic [31:0] exp_rd;
  } wb_vec_t;

  wb_vec_t vecs [9];

  initial begin
    int  n;
    logic [7:0] exp_tag;
    bit  wrapped;

    vecs[0] = '{1'b1, 5'd1,  32'hA001, 1'b1, 5'd2,  32'hB002, 1'b1, 1'b0, 8'd1, 5'd1,  32'hA001};
    vecs[1] = '{1'b1, 5'd3,  32'hA003, 1'b1, 5'd4,  32'hB004, 1'b0, 1'b1, 8'd2, 5'd4,  32'hB004};
    vecs[2] = '{1'b1, 5'd5,  32'hA005, 1'b1, 5'd6,  32'hB006, 1'b1, 1'b0, 8'd3, 5'd5,  32'hA005};
    vecs[3] = '{1'b1, 5'd7,  32'hA007, 1'b1, 5'd8,  32'hB008, 1'b0, 1'b1, 8'd4, 5'd8,  32'hB008};
    vecs[4] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'hB009, 1'b0, 1'b1, 8'd5, 5'd9,  32'hB009};
    vecs[5] = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 8'd5, 5'd9,  32'hB009};
    vecs[6] = '{1'b1, 5'd10, 32'hA00A, 1'b1, 5'd11, 32'hB00B, 1'b0, 1'b1, 8'd6, 5'd11, 32'hB00B};
    vecs[7] = '{1'b0, 5'd12, 32'hA00C, 1'b0, 5'd13, 32'hB00D, 1'b0, 1'b0, 8'd6, 5'd11, 32'hB00B};
    vecs[8] = '{1'b1, 5'd12, 32'hA00C, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 8'd7, 5'd12, 32'hA00C};

    bus.i_read_req = 0; bus.i_read_rs1_idx = 0; bus.i_read_rs2_idx = 0;
    bus.i_issue_valid = 0; bus.i_issue_rd = 0;
    bus.i_wb_alu_valid = 0; bus.i_wb_alu_rd = 0; bus.i_wb_alu_data = 0;
    bus.i_wb_lsu_valid = 0; bus.i_wb_lsu_rd = 0; bus.i_wb_lsu_data = 0;

    tick(); tick();
    check("reset_read_tag",  64'(bus.o_read_tag), 64'd0);
    check("reset_write_tag", 64'(bus.o_write_tag), 64'd0);
    check("reset_pending",   64'(bus.o_pending), 64'd0);
    check("reset_valid",     64'(bus.o_read_valid), 64'd0);
    i_reset = 0;
    tick();

    // Hazard-free read of x5,x6: tag moves on the edge after CHECK, valid at 3 cycles.
    bus.i_read_req = 1; bus.i_read_rs1_idx = 5'd5; bus.i_read_rs2_idx = 5'd6;
    tick();
    check("read_c1_tag",   64'(bus.o_read_tag), 64'd0);
    check("read_c1_valid", 64'(bus.o_read_valid), 64'd0);
    tick();
    check("read_c2_tag",   64'(bus.o_read_tag), 64'd1);
    check("read_c2_valid", 64'(bus.o_read_valid), 64'd0);
    tick();
    check("read_c3_valid", 64'(bus.o_read_valid), 64'd1);
    check("read_idx",      64'({bus.o_read_rs1_idx, bus.o_read_rs2_idx}), 64'({5'd5, 5'd6}));
    bus.i_read_req = 0;
    tick();
    check("read_pulse_end", 64'(bus.o_read_valid), 64'd0);

    // Writeback arbitration table.
    for (int i = 0; i < 9; i++) begin
      bus.i_wb_alu_valid = vecs[i].alu_v; bus.i_wb_alu_rd = vecs[i].alu_rd; bus.i_wb_alu_data = vecs[i].alu_d;
      bus.i_wb_lsu_valid = vecs[i].lsu_v; bus.i_wb_lsu_rd = vecs[i].lsu_rd; bus.i_wb_lsu_data = vecs[i].lsu_d;
      #1;
      check($sformatf("wb%0d_alu_ready", i), 64'(bus.o_wb_alu_ready), 64'(vecs[i].exp_alu_rdy));
      check($sformatf("wb%0d_lsu_ready", i), 64'(bus.o_wb_lsu_ready), 64'(vecs[i].exp_lsu_rdy));
      tick();
      bus.i_wb_alu_valid = 0; bus.i_wb_lsu_valid = 0;
      check($sformatf("wb%0d_tag", i), 64'(bus.o_write_tag), 64'(vecs[i].exp_tag));
      check($sformatf("wb%0d_idx", i), 64'(bus.o_write_rd_idx), 64'(vecs[i].exp_idx));
      check($sformatf("wb%0d_data", i), 64'(bus.o_rd), 64'(vecs[i].exp_rd));
    end
    tick();
    check("rf_r0_zero", 64'(rf_mem[0]), 64'd0);
    check("rf_r12",     64'(rf_mem[12]), 64'hA00C);
`ifdef CPU_REGSEQ_PERF_EN
    check("perf_conflicts", 64'(o_wb_conflicts), 64'd5);
`endif

    // RAW hazard on x5: read stalls in CHECK until the ALU writes x5.
    bus.i_issue_valid = 1; bus.i_issue_rd = 5'd5;
    #1;
    check("issue5_ready", 64'(bus.o_issue_ready), 64'd1);
    tick();
    bus.i_issue_valid = 0;
    check("issue5_pending", 64'(bus.o_pending), 64'h20);
    check("issue5_waw_block", 64'(bus.o_issue_ready), 64'd0);
    bus.i_read_req = 1; bus.i_read_rs1_idx = 5'd5; bus.i_read_rs2_idx = 5'd0;
    n = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (bus.o_read_valid) n++;
    end
    check("stall_no_valid", 64'(n), 64'd0);
    check("stall_read_tag", 64'(bus.o_read_tag), 64'd1);
    bus.i_wb_alu_valid = 1; bus.i_wb_alu_rd = 5'd5; bus.i_wb_alu_data = 32'hDEADBEEF;
    tick();
    bus.i_wb_alu_valid = 0;
    check("raw_pending_clear", 64'(bus.o_pending), 64'd0);
    check("raw_write_tag",     64'(bus.o_write_tag), 64'd8);
    check("raw_read_tag_held", 64'(bus.o_read_tag), 64'd1);
    wait_valid(10, n);
    check("raw_valid_latency", 64'(n), 64'd2);
    bus.i_read_req = 0;
    check("raw_rs1_value", 64'(rf_rs1), 64'hDEADBEEF);
    check("raw_read_tag",  64'(bus.o_read_tag), 64'd2);

    // WAW block on x7, then 256 writes wrapping the write tag.
    tick();
    bus.i_issue_valid = 1; bus.i_issue_rd = 5'd7;
    #1;
    check("issue7_first", 64'(bus.o_issue_ready), 64'd1);
    tick();
    check("issue7_second", 64'(bus.o_issue_ready), 64'd0);
    bus.i_issue_valid = 0;
    exp_tag = bus.o_write_tag;
    wrapped = 0;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      bus.i_wb_alu_valid = 1; bus.i_wb_alu_rd = 5'd7; bus.i_wb_alu_data = 32'(i);
      tick();
      if (exp_tag == 8'hFF) wrapped = (bus.o_write_tag == 8'h00);
      exp_tag = exp_tag + 8'd1;
      if (bus.o_write_tag != exp_tag) n++;
    end
    bus.i_wb_alu_valid = 0;
    check("wrap_tag_mismatches", 64'(n), 64'd0);
    check("wrap_ff_to_00", 64'(wrapped), 64'd1);
    check("wrap_final_tag", 64'(bus.o_write_tag), 64'd8);
    tick();
    check("wrap_rf_commit", 64'(rf_mem[7]), 64'd255);
    check("wrap_pending", 64'(bus.o_pending), 64'd0);

    // Asynchronous reset while stalled in CHECK.
    bus.i_issue_valid = 1; bus.i_issue_rd = 5'd9;
    tick();
    bus.i_issue_valid = 0;
    bus.i_read_req = 1; bus.i_read_rs1_idx = 5'd9; bus.i_read_rs2_idx = 5'd9;
    tick(); tick();
    #2;
    i_reset = 1;
    #1;
    check("arst_pending",   64'(bus.o_pending), 64'd0);
    check("arst_tags",      64'({bus.o_read_tag, bus.o_write_tag}), 64'd0);
    check("arst_outputs",   64'({bus.o_read_rs1_idx, bus.o_read_rs2_idx, bus.o_write_rd_idx, bus.o_rd}), 64'd0);
    bus.i_read_req = 0;
    tick();
    i_reset = 0;
    tick();
    bus.i_read_req = 1; bus.i_read_rs1_idx = 5'd1; bus.i_read_rs2_idx = 5'd2;
    wait_valid(10, n);
    bus.i_read_req = 0;
    check("arst_idle_latency", 64'(n), 64'd3);
    check("arst_read_tag",     64'(bus.o_read_tag), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
